// File: rtl/mem_read_ctrl_pkg.sv
// Shared definitions for the memory read sequencer: state encoding and defaults.
package mem_read_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    localparam int DEF_TIMEOUT = 16;
    localparam int DEF_CW      = 5;

endpackage

// File: rtl/mem_read_ctrl_enreg.sv
// Enabled register with asynchronous clear; loads d when en is high.
module mem_read_ctrl_enreg #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= '0;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/mem_read_ctrl.sv
// Read-side sequencer: runs the req/ready handshake with memory, captures the word,
// pulses the destination-register load enable and bounds each access with a timeout.
module mem_read_ctrl
    import mem_read_ctrl_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int CW      = DEF_CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req,
    input  logic [AW-1:0] addr,
    input  logic          clr,
    output logic          busy,
    output logic          mem_rd,
    output logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    output logic [DW-1:0] rd_data,
    output logic          ld_en,
    output logic          done,
    output logic          err,
    output logic          overrun
);

    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] cnt_q;
    logic          accept;
    logic          drop;
    logic          last_wait;
    logic          capture;

    // New requests are taken only from IDLE or DONE; anywhere else they are lost.
    assign accept    = req && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign drop      = req && ((state_q == ST_WAIT) || (state_q == ST_ERR));
    assign last_wait = (cnt_q == CW'(TIMEOUT - 1));
    assign capture   = (state_q == ST_WAIT) && mem_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (req) state_d = ST_WAIT;
            ST_WAIT: begin
                if (mem_ready)
                    state_d = ST_DONE;
                else if (last_wait)
                    state_d = ST_ERR;
            end
            ST_DONE: state_d = req ? ST_WAIT : ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy   = 1'b0;
        mem_rd = 1'b0;
        ld_en  = 1'b0;
        done   = 1'b0;
        err    = 1'b0;
        case (state_q)
            ST_WAIT: begin
                busy   = 1'b1;
                mem_rd = 1'b1;
            end
            ST_DONE: begin
                ld_en = 1'b1;
                done  = 1'b1;
            end
            ST_ERR:  err = 1'b1;
            default: ;
        endcase
    end

    // The timeout compare stops the count before it can wrap, so no saturation is needed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else if (accept)
            cnt_q <= '0;
        else if ((state_q == ST_WAIT) && !mem_ready && !last_wait)
            cnt_q <= cnt_q + 1'b1;
    end

    // A drop in the same cycle as clr keeps the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            overrun <= 1'b0;
        else if (drop)
            overrun <= 1'b1;
        else if (clr)
            overrun <= 1'b0;
    end

    mem_read_ctrl_enreg #(.W(AW)) u_addr_reg (
        .clk (clk),
        .rst (rst),
        .en  (accept),
        .d   (addr),
        .q   (mem_addr)
    );

    mem_read_ctrl_enreg #(.W(DW)) u_data_reg (
        .clk (clk),
        .rst (rst),
        .en  (capture),
        .d   (mem_rdata),
        .q   (rd_data)
    );

endmodule
